ctrl_rw_sched: RTL



---
 rtl/ctrl_rw_sched_if.sv | 32 +++
 rtl/ctrl_rw_sched.sv | 121 ++++++++++++
 2 files changed

// File: rtl/ctrl_rw_sched_if.sv
// Request/grant, refresh handshake and command/start-pulse bundle of the
// DDR4 read/write command scheduler.
interface ctrl_rw_sched_if #(
   parameter int unsigned ADDR_W = 28
) ();
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_gnt;
   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic              wr_gnt;
   logic              ref_req;
   logic              ref_ack;
   logic              cmd_valid;
   logic              cmd_is_rd;
   logic [ADDR_W-1:0] cmd_addr;
   logic              rd_start;
   logic              wr_start;
   logic              busy;

   modport master (
      output rd_req, rd_addr, wr_req, wr_addr, ref_req,
      input  rd_gnt, wr_gnt, ref_ack, cmd_valid, cmd_is_rd, cmd_addr,
             rd_start, wr_start, busy
   );

   modport slave (
      input  rd_req, rd_addr, wr_req, wr_addr, ref_req,
      output rd_gnt, wr_gnt, ref_ack, cmd_valid, cmd_is_rd, cmd_addr,
             rd_start, wr_start, busy
   );
endinterface

// File: rtl/ctrl_rw_sched.sv
// DDR4 read/write command scheduler: round-robin grant with tCCD/turnaround
// spacing, delayed data-path start pulses and refresh drain/hold.
module ctrl_rw_sched #(
   parameter int unsigned ADDR_W       = 28,
   parameter int unsigned TCCD         = 4,
   parameter int unsigned T_RD2WR      = 8,
   parameter int unsigned T_WR2RD      = 16,
   parameter int unsigned RD_START_DLY = 14,
   parameter int unsigned WR_START_DLY = 10
) (
   input logic            CK_t,
   input logic            reset_n,
   ctrl_rw_sched_if.slave bus
);
   localparam int unsigned BLK_W = 5;
   localparam int unsigned SR_W  = 32;
   localparam logic [BLK_W-1:0] TCCD_M1  = BLK_W'(TCCD - 1);
   localparam logic [BLK_W-1:0] RD2WR_M1 = BLK_W'(T_RD2WR - 1);
   localparam logic [BLK_W-1:0] WR2RD_M1 = BLK_W'(T_WR2RD - 1);
   localparam logic [SR_W-1:0]  RD_TAP   = SR_W'(1) << RD_START_DLY;
   localparam logic [SR_W-1:0]  WR_TAP   = SR_W'(1) << WR_START_DLY;

   typedef enum logic [1:0] {NORMAL = 2'd0, DRAIN = 2'd1, HOLD = 2'd2} state_t;

   state_t            state, state_next;
   logic [BLK_W-1:0]  rd_blk, wr_blk, rd_blk_next, wr_blk_next, rd_blk_dec, wr_blk_dec;
   logic [SR_W-1:0]   rd_sr, wr_sr, rd_sr_next, wr_sr_next;
   logic              ptr, ptr_next;  // 0: read wins a tie
   logic              rd_elig_c, wr_elig_c, rd_gnt_c, wr_gnt_c;
   logic              cmd_valid, cmd_valid_next, cmd_is_rd, cmd_is_rd_next;
   logic [ADDR_W-1:0] cmd_addr, cmd_addr_next;
   logic              ref_ack, ref_ack_next, busy, busy_next;

   // Registered state, command and pulse pipelines
   always_ff @(posedge CK_t or negedge reset_n) begin
      if (!reset_n) begin
         state     <= NORMAL;
         rd_blk    <= '0;
         wr_blk    <= '0;
         rd_sr     <= '0;
         wr_sr     <= '0;
         ptr       <= 1'b0;
         cmd_valid <= 1'b0;
         cmd_is_rd <= 1'b0;
         cmd_addr  <= '0;
         ref_ack   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_next;
         rd_blk    <= rd_blk_next;
         wr_blk    <= wr_blk_next;
         rd_sr     <= rd_sr_next;
         wr_sr     <= wr_sr_next;
         ptr       <= ptr_next;
         cmd_valid <= cmd_valid_next;
         cmd_is_rd <= cmd_is_rd_next;
         cmd_addr  <= cmd_addr_next;
         ref_ack   <= ref_ack_next;
         busy      <= busy_next;
      end
   end

   // Arbitration, spacing counters, start pipelines and refresh FSM
   always_comb begin
      state_next     = state;
      ptr_next       = ptr;
      cmd_is_rd_next = cmd_is_rd;
      cmd_addr_next  = cmd_addr;

      // Grants reopen in HOLD once refresh is released; never during a drain
      rd_elig_c = reset_n && bus.rd_req && (rd_blk == '0) && (state != DRAIN) && !bus.ref_req;
      wr_elig_c = reset_n && bus.wr_req && (wr_blk == '0) && (state != DRAIN) && !bus.ref_req;
      rd_gnt_c  = rd_elig_c && (!wr_elig_c || !ptr);
      wr_gnt_c  = wr_elig_c && !rd_gnt_c;
      if (rd_elig_c && wr_elig_c) ptr_next = !ptr;

      rd_blk_dec  = (rd_blk == '0) ? '0 : rd_blk - BLK_W'(1);
      wr_blk_dec  = (wr_blk == '0) ? '0 : wr_blk - BLK_W'(1);
      rd_blk_next = rd_blk_dec;
      wr_blk_next = wr_blk_dec;
      if (rd_gnt_c) begin
         rd_blk_next = (rd_blk_dec > TCCD_M1)  ? rd_blk_dec : TCCD_M1;
         wr_blk_next = (wr_blk_dec > RD2WR_M1) ? wr_blk_dec : RD2WR_M1;
      end else if (wr_gnt_c) begin
         wr_blk_next = (wr_blk_dec > TCCD_M1)  ? wr_blk_dec : TCCD_M1;
         rd_blk_next = (rd_blk_dec > WR2RD_M1) ? rd_blk_dec : WR2RD_M1;
      end

      rd_sr_next = (rd_sr >> 1) | (rd_gnt_c ? RD_TAP : '0);
      wr_sr_next = (wr_sr >> 1) | (wr_gnt_c ? WR_TAP : '0);

      cmd_valid_next = rd_gnt_c || wr_gnt_c;
      if (cmd_valid_next) begin
         cmd_is_rd_next = rd_gnt_c;
         cmd_addr_next  = rd_gnt_c ? bus.rd_addr : bus.wr_addr;
      end

      // Drain completes on the edge where every pipeline empties
      case (state)
         NORMAL:  if (bus.ref_req) state_next = DRAIN;
         DRAIN:   if (!cmd_valid_next && (rd_sr_next == '0) && (wr_sr_next == '0) &&
                      (rd_blk_next == '0) && (wr_blk_next == '0)) state_next = HOLD;
         HOLD:    if (!bus.ref_req) state_next = NORMAL;
         default: state_next = NORMAL;
      endcase

      ref_ack_next = (state_next == HOLD);
      busy_next    = cmd_valid_next || (rd_sr_next != '0) || (wr_sr_next != '0) ||
                     (state_next != NORMAL);
   end

   assign bus.rd_gnt    = rd_gnt_c;
   assign bus.wr_gnt    = wr_gnt_c;
   assign bus.cmd_valid = cmd_valid;
   assign bus.cmd_is_rd = cmd_is_rd;
   assign bus.cmd_addr  = cmd_addr;
   assign bus.rd_start  = rd_sr[0];
   assign bus.wr_start  = wr_sr[0];
   assign bus.ref_ack   = ref_ack;
   assign bus.busy      = busy;
endmodule
